// File: rtl/sixteen_segment_sniffer.sv
// sixteen_segment_sniffer
// Watches the 16 active-low segment lines plus dp of a one-segment-at-a-time
// scan driver, accumulates the segments seen lit over one frame and decodes
// the frame to a hex digit.
//
// Optional feature: define SIXTEEN_SEG_CONFIRM_EN to accept a matched frame
// only when its pattern repeats the previous frame's pattern.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_ACCUM   | accumulating qualified-lit flags until the last frame cycle
// ST_EVAL    | table lookup on the snapshot of the finished frame
// ST_PUBLISH | register pattern/digit/unknown, pulse frame_done (and changed)
//
// The frame counter and the accumulator never pause: the next frame is
// collected while the finished one is evaluated from its snapshot.
module sixteen_segment_sniffer #(
    parameter int FRAME_CYCLES = 131072,
    parameter int MIN_LIT      = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] seg_n,
    input  logic        dp_n,
    output logic [15:0] pattern,
    output logic [3:0]  digit,
    output logic        digit_dp,
    output logic        unknown,
    output logic        frame_done,
    output logic        changed
);

    localparam int             FCW        = $clog2(FRAME_CYCLES);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_CYCLES - 1);
    localparam logic [7:0]     MIN_LIT_C  = 8'(MIN_LIT);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_EVAL    = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [16:0]    r_sync1;
    logic [16:0]    r_sync2;
    logic [7:0]     r_run [17];
    logic [16:0]    w_qual;

    logic [FCW-1:0] r_frame_cnt;
    logic           w_frame_end;
    logic [16:0]    r_lit_acc;
    logic [16:0]    r_eval_acc;
    logic [15:0]    w_eval_pat;

    logic           w_lut_hit;
    logic [3:0]     w_lut_digit;
    logic           r_hit;
    logic [3:0]     r_hit_digit;
    logic           w_accept;
    logic           w_changed;

    logic [15:0]    r_pattern;
    logic [3:0]     r_digit;
    logic           r_digit_dp;
    logic           r_unknown;
    logic           r_frame_done;
    logic           r_changed;

    assign pattern    = r_pattern;
    assign digit      = r_digit;
    assign digit_dp   = r_digit_dp;
    assign unknown    = r_unknown;
    assign frame_done = r_frame_done;
    assign changed    = r_changed;

    // Two-flop synchronizer on {dp, segments}; resets to dark.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {dp_n, seg_n};
            r_sync2 <= r_sync1;
        end
    end

    // Per-line glitch filter: count consecutive low samples, saturate at MIN_LIT.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < 17; i++) r_run[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 17; i++) begin
                if (r_sync2[i])
                    r_run[i] <= 8'd0;
                else if (r_run[i] != MIN_LIT_C)
                    r_run[i] <= r_run[i] + 8'd1;
            end
        end
    end

    // A line is qualified lit on every cycle its run counter sits at MIN_LIT.
    always_comb begin
        w_qual = '0;
        for (int i = 0; i < 17; i++) w_qual[i] = (r_run[i] == MIN_LIT_C);
    end

    assign w_frame_end = (r_state == ST_ACCUM) && (r_frame_cnt == FRAME_LAST);

    // Free-running frame counter 0..FRAME_CYCLES-1.
    always_ff @(posedge CLK) begin
        if (reset)
            r_frame_cnt <= '0;
        else if (r_frame_cnt == FRAME_LAST)
            r_frame_cnt <= '0;
        else
            r_frame_cnt <= r_frame_cnt + FCW'(1);
    end

    // Accumulate lit flags; at frame end snapshot the frame and seed the next one
    // with this cycle's flags so no sample falls between frames.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_lit_acc  <= '0;
            r_eval_acc <= '0;
        end else if (w_frame_end) begin
            r_eval_acc <= r_lit_acc;
            r_lit_acc  <= w_qual;
        end else begin
            r_lit_acc  <= r_lit_acc | w_qual;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (reset)
            r_state <= ST_ACCUM;
        else
            r_state <= w_state_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM:   if (w_frame_end) w_state_next = ST_EVAL;
            ST_EVAL:    w_state_next = ST_PUBLISH;
            ST_PUBLISH: w_state_next = ST_ACCUM;
            default:    w_state_next = ST_ACCUM;
        endcase
    end

    assign w_eval_pat = ~r_eval_acc[15:0];

    // Exact-match lookup of the active-low frame pattern to a hex digit.
    always_comb begin
        w_lut_hit   = 1'b1;
        w_lut_digit = 4'h0;
        case (w_eval_pat)
            16'h00FF: w_lut_digit = 4'h0;
            16'hCFFF: w_lut_digit = 4'h1;
            16'h11E7: w_lut_digit = 4'h2;
            16'h03E7: w_lut_digit = 4'h3;
            16'hCEE7: w_lut_digit = 4'h4;
            16'h22E7: w_lut_digit = 4'h5;
            16'h20E7: w_lut_digit = 4'h6;
            16'h0FFF: w_lut_digit = 4'h7;
            16'h00E7: w_lut_digit = 4'h8;
            16'h02E7: w_lut_digit = 4'h9;
            16'h0CE7: w_lut_digit = 4'hA;
            16'hE0E7: w_lut_digit = 4'hB;
            16'h30FF: w_lut_digit = 4'hC;
            16'hC1E7: w_lut_digit = 4'hD;
            16'h30EF: w_lut_digit = 4'hE;
            16'h3CEF: w_lut_digit = 4'hF;
            default:  w_lut_hit   = 1'b0;
        endcase
    end

    // Hold the lookup result for the publish cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_hit       <= 1'b0;
            r_hit_digit <= 4'h0;
        end else if (r_state == ST_EVAL) begin
            r_hit       <= w_lut_hit;
            r_hit_digit <= w_lut_digit;
        end
    end

`ifdef SIXTEEN_SEG_CONFIRM_EN
    // The published pattern register doubles as the previous-frame pattern.
    assign w_accept = r_hit && (w_eval_pat == r_pattern);
`else
    assign w_accept = r_hit;
`endif

    assign w_changed = w_accept && ({r_hit_digit, r_eval_acc[16]} != {r_digit, r_digit_dp});

    // Publish the frame result and generate the one-cycle pulses.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pattern    <= 16'hFFFF;
            r_digit      <= 4'h0;
            r_digit_dp   <= 1'b0;
            r_unknown    <= 1'b1;
            r_frame_done <= 1'b0;
            r_changed    <= 1'b0;
        end else begin
            r_frame_done <= (r_state == ST_PUBLISH);
            r_changed    <= (r_state == ST_PUBLISH) && w_changed;
            if (r_state == ST_PUBLISH) begin
                r_pattern <= w_eval_pat;
                r_unknown <= !r_hit;
                if (w_accept) begin
                    r_digit    <= r_hit_digit;
                    r_digit_dp <= r_eval_acc[16];
                end
            end
        end
    end

endmodule
